// File: rtl/stump_sequencer_pkg.sv
// Shared Stump definitions: sequencer state encodings and the LDST opcode.
// Imported by the sequencer and its wait timer.
package stump_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10
    } stump_state_e;

    localparam logic [2:0] LDST = 3'b111;

    localparam int TIMER_W = 16;

    function automatic logic is_mem_state(input logic [1:0] s);
        return (s == FETCH) || (s == MEMORY);
    endfunction

endpackage

// File: rtl/stump_sequencer_wait_timer.sv
// Consecutive not-ready cycle counter; expired fires in the cycle
// that would make the WAIT_LIMIT-th consecutive stall.
module stump_wait_timer
    import stump_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(WAIT_LIMIT - 1);

    logic [TIMER_W-1:0] count;

    assign expired = count_en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/stump_sequencer.sv
// Stump fetch/execute/memory sequencer with wait states, debug run control,
// bus timeout abort and retired-instruction / stall counters.
module stump_sequencer
    import stump_sequencer_pkg::*;
#(
    parameter bit          START_HALTED = 1'b0,
    parameter int unsigned WAIT_LIMIT   = 255,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             mem_ready,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             cnt_clr,
    output logic [1:0]       state,
    output logic             mem_req,
    output logic             commit,
    output logic             ir_en,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    stump_state_e state_q, state_d;
    logic         halted_q, halted_d;
    logic         pend_q, pend_d;
    logic         berr_q, berr_d;
    logic         stall;
    logic         retire;
    logic         expired;
    logic         is_ldst;

    assign is_ldst = (opcode == LDST);

    // Strobes are forced low during reset so an in-flight access is dropped.
    assign mem_req = ~rst & ~halted_q & is_mem_state(state_q);
    assign stall   = mem_req & ~mem_ready;

    always_comb begin
        commit = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH, MEMORY: commit = mem_req & mem_ready;
                EXECUTE:       commit = ~halted_q;
                default:       commit = 1'b0;
            endcase
        end
    end

    assign ir_en  = commit & (state_q == FETCH);
    assign retire = commit &
                    (((state_q == EXECUTE) & ~is_ldst) |
                     (state_q == MEMORY));

    stump_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en (stall),
        .clear    (commit),
        .expired  (expired)
    );

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        pend_d   = pend_q;
        berr_d   = berr_q;

        case (state_q)
            FETCH:   if (commit) state_d = EXECUTE;
            EXECUTE: if (commit) state_d = is_ldst ? MEMORY : FETCH;
            MEMORY:  if (commit) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        if (expired) begin
            state_d  = FETCH;
            halted_d = 1'b1;
            pend_d   = 1'b0;
            berr_d   = 1'b1;
        end else if (halted_q) begin
            state_d = FETCH;
            // halt_req outranks run/step; step outranks run.
            if (halt_req) begin
                halted_d = 1'b1;
            end else if (step_req) begin
                halted_d = 1'b0;
                pend_d   = 1'b1;
            end else if (run_req) begin
                halted_d = 1'b0;
                berr_d   = 1'b0;
            end
        end else begin
            if (halt_req) pend_d = 1'b1;
            if (retire && pend_q) begin
                state_d  = FETCH;
                halted_d = 1'b1;
                pend_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            halted_q <= START_HALTED;
            pend_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            pend_q   <= pend_d;
            berr_q   <= berr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
            stall_count <= '0;
        end else if (cnt_clr) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign state     = state_q;
    assign halted    = halted_q;
    assign bus_error = berr_q;

endmodule

// File: tb/tb_stump_sequencer.sv
// Directed bench for stump_sequencer: sequencing, wait states, debug
// control, bus timeout, counter clear and mid-access reset.
module tb_stump_sequencer;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b111;

    logic        clk;
    logic        rst;
    logic [2:0]  opcode;
    logic        mem_ready;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        cnt_clr;
    logic [1:0]  state;
    logic        mem_req;
    logic        commit;
    logic        ir_en;
    logic        halted;
    logic        bus_error;
    logic [15:0] instr_count;
    logic [15:0] stall_count;

    logic [1:0]  state_h;
    logic        mem_req_h;
    logic        commit_h;
    logic        ir_en_h;
    logic        halted_h;
    logic        bus_error_h;
    logic [15:0] instr_count_h;
    logic [15:0] stall_count_h;

    int errors = 0;
    int checks = 0;

    stump_sequencer #(
        .START_HALTED (1'b0),
        .WAIT_LIMIT   (4),
        .CNT_W        (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .cnt_clr     (cnt_clr),
        .state       (state),
        .mem_req     (mem_req),
        .commit      (commit),
        .ir_en       (ir_en),
        .halted      (halted),
        .bus_error   (bus_error),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    stump_sequencer #(
        .START_HALTED (1'b1),
        .WAIT_LIMIT   (4),
        .CNT_W        (16)
    ) u_dut_h (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .cnt_clr     (cnt_clr),
        .state       (state_h),
        .mem_req     (mem_req_h),
        .commit      (commit_h),
        .ir_en       (ir_en_h),
        .halted      (halted_h),
        .bus_error   (bus_error_h),
        .instr_count (instr_count_h),
        .stall_count (stall_count_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = OP_ADD;
        mem_ready = 1'b1;
        run_req = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        cnt_clr = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL rst_state got=%0d exp=0", state);
        end
        checks++;
        if (commit !== 1'b0 || mem_req !== 1'b0 || ir_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobes got=%b%b%b exp=000",
                     commit, mem_req, ir_en);
        end
        checks++;
        if (instr_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_counts got=%0d/%0d exp=0/0",
                     instr_count, stall_count);
        end
        checks++;
        if (halted !== 1'b0 || halted_h !== 1'b1 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_halted got=%b/%b berr=%b exp=0/1 berr=0",
                     halted, halted_h, bus_error);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_ldr();
        logic [2:0] ops [6];
        logic [1:0] exp_st [6];
        logic       exp_ir [6];
        ops    = '{OP_ADD, OP_ADD, OP_LD, OP_LD, OP_LD, OP_ADD};
        exp_st = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        exp_ir = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if (state !== exp_st[i] || ir_en !== exp_ir[i]) begin
                errors++;
                $display("FAIL seq_c%0d got st=%0d ir=%b exp st=%0d ir=%b",
                         i, state, ir_en, exp_st[i], exp_ir[i]);
            end
            if (i < 5) tick();
        end
        checks++;
        if (instr_count !== 16'd2) begin
            errors++;
            $display("FAIL seq_instr got=%0d exp=2", instr_count);
        end
    endtask

    task automatic test_wait_states();
        opcode = OP_ADD;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== 2'b00 || commit !== 1'b0) begin
                errors++;
                $display("FAIL wait_c%0d got st=%0d cm=%b exp st=0 cm=0",
                         i, state, commit);
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (stall_count !== 16'd3 || commit !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall got=%0d cm=%b exp=3 cm=1",
                     stall_count, commit);
        end
        tick();
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL wait_exec got=%0d exp=1", state);
        end
        tick();
        checks++;
        if (state !== 2'b00 || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL wait_retire got st=%0d ic=%0d exp st=0 ic=3",
                     state, instr_count);
        end
    endtask

    task automatic test_halt();
        opcode = OP_LD;
        tick();
        halt_req = 1'b1;
        #1;
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL halt_exec got=%0d exp=1", state);
        end
        tick();
        halt_req = 1'b0;
        checks++;
        if (state !== 2'b10 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_mem got st=%0d h=%b exp st=2 h=0",
                     state, halted);
        end
        tick();
        checks++;
        if (state !== 2'b00 || halted !== 1'b1 || mem_req !== 1'b0 ||
            commit !== 1'b0 || instr_count !== 16'd4) begin
            errors++;
            $display("FAIL halt_done got st=%0d h=%b mr=%b cm=%b ic=%0d exp 0 1 0 0 4",
                     state, halted, mem_req, commit, instr_count);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || instr_count !== 16'd4) begin
            errors++;
            $display("FAIL halt_hold got h=%b ic=%0d exp h=1 ic=4",
                     halted, instr_count);
        end
    endtask

    task automatic test_step();
        logic [15:0] ic0;
        int          n;
        int          exp_n;
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? OP_ADD : OP_LD;
            exp_n  = (k == 0) ? 2 : 3;
            ic0 = instr_count;
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            checks++;
            if (halted !== 1'b0) begin
                errors++;
                $display("FAIL step%0d_run got=%b exp=0", k, halted);
            end
            n = 0;
            while (!halted && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n !== exp_n || instr_count !== ic0 + 16'd1 ||
                state !== 2'b00) begin
                errors++;
                $display("FAIL step%0d got n=%0d ic=%0d st=%0d exp n=%0d ic=%0d st=0",
                         k, n, instr_count, state, exp_n, ic0 + 16'd1);
            end
        end
    endtask

    task automatic test_priority();
        logic [15:0] ic0;
        int          n;
        halt_req = 1'b1;
        run_req = 1'b1;
        tick();
        halt_req = 1'b0;
        run_req = 1'b0;
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL prio_halt_run got=%b exp=1", halted);
        end
        opcode = OP_ADD;
        ic0 = instr_count;
        step_req = 1'b1;
        run_req = 1'b1;
        tick();
        step_req = 1'b0;
        run_req = 1'b0;
        n = 0;
        while (!halted && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 2 || instr_count !== ic0 + 16'd1) begin
            errors++;
            $display("FAIL prio_step_run got n=%0d ic=%0d exp n=2 ic=%0d",
                     n, instr_count, ic0 + 16'd1);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] ic0;
        logic [15:0] sc0;
        ic0 = instr_count;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL to_run got=%b exp=0", halted);
        end
        opcode = OP_LD;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        sc0 = stall_count;
        for (int c = 0; c < 4; c++) begin
            halt_req = (c == 3);
            #1;
            checks++;
            if (commit !== 1'b0 || bus_error !== 1'b0 || state !== 2'b10) begin
                errors++;
                $display("FAIL to_c%0d got cm=%b be=%b st=%0d exp cm=0 be=0 st=2",
                         c, commit, bus_error, state);
            end
            tick();
        end
        halt_req = 1'b0;
        checks++;
        if (bus_error !== 1'b1 || halted !== 1'b1 || state !== 2'b00 ||
            mem_req !== 1'b0) begin
            errors++;
            $display("FAIL to_abort got be=%b h=%b st=%0d mr=%b exp 1 1 0 0",
                     bus_error, halted, state, mem_req);
        end
        checks++;
        if (stall_count !== sc0 + 16'd4 || instr_count !== ic0) begin
            errors++;
            $display("FAIL to_counts got sc=%0d ic=%0d exp sc=%0d ic=%0d",
                     stall_count, instr_count, sc0 + 16'd4, ic0);
        end
        run_req = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_ADD;
        tick();
        run_req = 1'b0;
        checks++;
        if (bus_error !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL to_resume got be=%b h=%b exp be=0 h=0",
                     bus_error, halted);
        end
        tick();
        tick();
        checks++;
        if (instr_count !== ic0 + 16'd1 || state !== 2'b00) begin
            errors++;
            $display("FAIL to_retire got ic=%0d st=%0d exp ic=%0d st=0",
                     instr_count, state, ic0 + 16'd1);
        end
    endtask

    task automatic test_cnt_clr();
        opcode = OP_ADD;
        mem_ready = 1'b1;
        tick();
        cnt_clr = 1'b1;
        #1;
        checks++;
        if (commit !== 1'b1 || state !== 2'b01) begin
            errors++;
            $display("FAIL clr_pre got cm=%b st=%0d exp cm=1 st=1",
                     commit, state);
        end
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (instr_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL clr got ic=%0d sc=%0d exp 0/0",
                     instr_count, stall_count);
        end
        tick();
        tick();
        checks++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL clr_after got=%0d exp=1", instr_count);
        end
    endtask

    task automatic test_reset_mid();
        opcode = OP_LD;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 2'b10 || commit !== 1'b1 || stall_count !== 16'd1 ||
            instr_count !== 16'd1) begin
            errors++;
            $display("FAIL rmid_pre got st=%0d cm=%b sc=%0d ic=%0d exp 2 1 1 1",
                     state, commit, stall_count, instr_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'b00 || commit !== 1'b0 || mem_req !== 1'b0 ||
            ir_en !== 1'b0) begin
            errors++;
            $display("FAIL rmid_strobes got st=%0d cm=%b mr=%b ir=%b exp 0 0 0 0",
                     state, commit, mem_req, ir_en);
        end
        checks++;
        if (instr_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rmid_counts got ic=%0d sc=%0d exp 0/0",
                     instr_count, stall_count);
        end
        checks++;
        if (halted !== 1'b0 || halted_h !== 1'b1) begin
            errors++;
            $display("FAIL rmid_halted got=%b/%b exp=0/1", halted, halted_h);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || halted !== 1'b0 || halted_h !== 1'b1 ||
            bus_error !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release got st=%0d h=%b/%b be=%b exp 0 0/1 0",
                     state, halted, halted_h, bus_error);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_ldr();
        test_wait_states();
        test_halt();
        test_step();
        test_priority();
        test_timeout();
        test_cnt_clr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
